// File: rtl/boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the boot loader and its testbench: the loader FSM
// state encoding and the byte-stream framing constants.
//   state_t        : loader FSM states
//   HEADER_BYTES   : number of length bytes that open a stream
//   BYTES_PER_WORD : payload bytes packed into one instruction word
// -----------------------------------------------------------------------------
package boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_LEN_HI = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_DATA   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   localparam int unsigned HEADER_BYTES   = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// boot_loader_byte_packer
// Packs accepted payload bytes MSB-first into 32-bit words. The completed
// word is presented combinationally on the cycle the last byte of a group
// is accepted, so the loader can register it without stalling the stream.
//   i_clock     : clock, rising edge
//   i_reset     : synchronous reset, active-low
//   i_clear     : synchronous clear of the partial word
//   i_accept    : a payload byte is accepted this cycle
//   i_byte      : the payload byte
//   o_word_done : this accept completes a word
//   o_word      : the completed word (valid while o_word_done = 1)
// -----------------------------------------------------------------------------
module boot_loader_byte_packer
   import boot_loader_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic        o_word_done,
   output logic [31:0] o_word
);

   logic [23:0] r_shift;
   logic [1:0]  r_count;

   assign o_word_done = i_accept && (r_count == 2'(BYTES_PER_WORD - 1));
   // The earlier three bytes already sit in r_shift, oldest in the top byte.
   assign o_word      = {r_shift, i_byte};

   always_ff @(posedge i_clock) begin
      if (!i_reset || i_clear) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (i_accept) begin
         r_shift <= {r_shift[15:0], i_byte};
         // Wraps from 3 back to 0 as each word completes.
         r_count <= r_count + 2'd1;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Receives a framed byte stream (2 length bytes, N*4 payload bytes, 1 XOR
// checksum byte), writes each payload word into instruction memory and
// releases the CPU from reset only after a good checksum.
//   clock            : clock, rising edge
//   reset            : synchronous reset, active-low
//   in_valid/in_data : upstream byte stream
//   in_ready         : loader accepts a byte this cycle
//   restart          : re-arm from DONE or ERROR
//   mem_write_enable : one-cycle instruction-memory write strobe
//   mem_address      : word address of the write
//   mem_data         : word to write
//   cpu_reset        : hold CPU in reset (active-high)
//   done / error     : load succeeded / load failed
// -----------------------------------------------------------------------------
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  restart,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_data,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

   state_t                r_state;
   logic [7:0]            r_len_hi;
   logic [7:0]            r_checksum;
   logic [ADDR_WIDTH-1:0] r_word_cnt;
   logic [ADDR_WIDTH-1:0] r_last_word;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_data;
   logic                  r_cpu_reset;
   logic                  r_done;
   logic                  r_error;

   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_pack_accept;
   logic                  w_clear;
   logic                  w_word_done;
   logic [31:0]           w_word;
   logic [31:0]           w_len;

   // Ready is gated by reset so no byte looks accepted while reset is held.
   assign w_in_ready    = reset && (r_state == ST_LEN_HI || r_state == ST_LEN_LO ||
                                    r_state == ST_DATA   || r_state == ST_CHECK);
   assign w_accept      = in_valid && w_in_ready;
   assign w_pack_accept = w_accept && (r_state == ST_DATA);
   assign w_clear       = restart && (r_state == ST_DONE || r_state == ST_ERROR);
   // Full word count, widened so N = 2^ADDR_WIDTH is still representable.
   assign w_len         = {16'd0, r_len_hi, in_data};

   boot_loader_byte_packer u_packer (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_clear     (w_clear),
      .i_accept    (w_pack_accept),
      .i_byte      (in_data),
      .o_word_done (w_word_done),
      .o_word      (w_word)
   );

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values; blocking would create order-dependent logic.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_LEN_HI;
         r_len_hi    <= '0;
         r_checksum  <= '0;
         r_word_cnt  <= '0;
         r_last_word <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_cpu_reset <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         // Strobe defaults low; only a word-completing accept raises it.
         r_mem_we <= 1'b0;
         case (r_state)
            ST_LEN_HI: begin
               if (w_accept) begin
                  r_len_hi <= in_data;
                  r_state  <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (w_accept) begin
                  if (w_len == 32'd0) begin
                     r_state <= ST_CHECK;
                  end else if (w_len > MAX_WORDS) begin
                     r_state <= ST_ERROR;
                     r_error <= 1'b1;
                  end else begin
                     r_state     <= ST_DATA;
                     r_word_cnt  <= '0;
                     r_last_word <= ADDR_WIDTH'(w_len - 32'd1);
                  end
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  r_checksum <= r_checksum ^ in_data;
                  if (w_word_done) begin
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= r_word_cnt;
                     r_mem_data <= w_word;
                     // Counter stops at the last word so it never overflows
                     // when N = 2^ADDR_WIDTH.
                     if (r_word_cnt == r_last_word) begin
                        r_state <= ST_CHECK;
                     end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (w_accept) begin
                  if (in_data == r_checksum) begin
                     r_state     <= ST_DONE;
                     r_done      <= 1'b1;
                     r_cpu_reset <= 1'b0;
                  end else begin
                     r_state <= ST_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (restart) begin
                  r_state     <= ST_LEN_HI;
                  r_len_hi    <= '0;
                  r_checksum  <= '0;
                  r_word_cnt  <= '0;
                  r_last_word <= '0;
                  r_cpu_reset <= 1'b1;
                  r_done      <= 1'b0;
                  r_error     <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_LEN_HI;
            end
         endcase
      end
   end

   assign in_ready         = w_in_ready;
   assign mem_write_enable = r_mem_we;
   assign mem_address      = r_mem_addr;
   assign mem_data         = r_mem_data;
   assign cpu_reset        = r_cpu_reset;
   assign done             = r_done;
   assign error            = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Directed bench for boot_loader: drives framed byte streams, records every
// memory write strobe and compares against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_boot_loader;
   import boot_loader_pkg::*;

   localparam int AW = 10;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          restart;
   logic          mem_write_enable;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_data;
   logic          cpu_reset;
   logic          done;
   logic          error;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  stream [$];
   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];

   boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clock            (clock),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .restart          (restart),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_data         (mem_data),
      .cpu_reset        (cpu_reset),
      .done             (done),
      .error            (error)
   );

   always #5 clock = ~clock;

   // Write monitor: each strobe is high for exactly one cycle, so one
   // negedge sample records each write once.
   always @(negedge clock) begin
      if (mem_write_enable === 1'b1) begin
         wr_addr.push_back(32'(mem_address));
         wr_data.push_back(mem_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one byte from a negedge and returns at the negedge after it is
   // accepted; gives up after a bounded wait for in_ready.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("byte_accepted", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clock);
         @(negedge clock);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_stream(input bit gaps);
      wr_addr.delete();
      wr_data.delete();
      foreach (stream[i]) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
         send_byte(stream[i]);
      end
      @(negedge clock);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check({tag, "_in_ready"},  32'(in_ready), 32'd0);
      check({tag, "_mem_we"},    32'(mem_write_enable), 32'd0);
      check({tag, "_mem_addr"},  32'(mem_address), 32'd0);
      check({tag, "_mem_data"},  mem_data, 32'd0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_done"},      32'(done), 32'd0);
      check({tag, "_error"},     32'(error), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_good_load(input string tag);
      check({tag, "_nwrites"}, 32'(wr_addr.size()),
            32'((stream.size() - HEADER_BYTES - 1) / BYTES_PER_WORD));
      if (wr_addr.size() == 2) begin
         check({tag, "_addr0"}, wr_addr[0], 32'd0);
         check({tag, "_data0"}, wr_data[0], 32'h3C01_0101);
         check({tag, "_addr1"}, wr_addr[1], 32'd1);
         check({tag, "_data1"}, wr_data[1], 32'h3421_0101);
      end
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      restart  = 1'b0;
      @(negedge clock);

      // Reset state.
      apply_reset("rst");

      // Good two-word load.
      stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h01, 8'h01,
                 8'h34, 8'h21, 8'h01, 8'h01, 8'h28};
      send_stream(1'b0);
      check_good_load("good");
      check("good_done",      32'(done), 32'd1);
      check("good_error",     32'(error), 32'd0);
      check("good_cpu_reset", 32'(cpu_reset), 32'd0);
      check("good_in_ready",  32'(in_ready), 32'd0);

      // Restart from DONE.
      pulse_restart();
      check("rs1_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rs1_done",      32'(done), 32'd0);
      check("rs1_in_ready",  32'(in_ready), 32'd1);

      // Bad checksum: writes still happen, then ERROR.
      stream[10] = 8'h29;
      send_stream(1'b0);
      check_good_load("badck");
      check("badck_error",     32'(error), 32'd1);
      check("badck_done",      32'(done), 32'd0);
      check("badck_cpu_reset", 32'(cpu_reset), 32'd1);
      check("badck_in_ready",  32'(in_ready), 32'd0);

      // N = 0 with restart pulsed in LEN_LO (must be ignored).
      pulse_restart();
      wr_addr.delete();
      wr_data.delete();
      send_byte(8'h00);
      pulse_restart();
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clock);
      check("n0_nwrites", 32'(wr_addr.size()), 32'd0);
      check("n0_done",    32'(done), 32'd1);
      check("n0_error",   32'(error), 32'd0);

      // N = 0 with wrong checksum.
      pulse_restart();
      stream = '{8'h00, 8'h00, 8'h05};
      send_stream(1'b0);
      check("n0bad_nwrites", 32'(wr_addr.size()), 32'd0);
      check("n0bad_error",   32'(error), 32'd1);
      check("n0bad_done",    32'(done), 32'd0);

      // N = 1025 exceeds capacity: ERROR on the LEN_LO accept.
      pulse_restart();
      stream = '{8'h04, 8'h01};
      send_stream(1'b0);
      check("ovf_error",    32'(error), 32'd1);
      check("ovf_in_ready", 32'(in_ready), 32'd0);

      // N = 1024 is exactly capacity: enters DATA, still accepting.
      pulse_restart();
      stream = '{8'h04, 8'h00};
      send_stream(1'b0);
      check("max_error",    32'(error), 32'd0);
      check("max_in_ready", 32'(in_ready), 32'd1);
      apply_reset("rst_max");

      // Reset after three payload bytes of word 0: no write issued.
      stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h01};
      send_stream(1'b0);
      apply_reset("rst_mid");
      check("rst_mid_nwrites", 32'(wr_addr.size()), 32'd0);

      // Fresh good stream with random valid gaps.
      stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h01, 8'h01,
                 8'h34, 8'h21, 8'h01, 8'h01, 8'h28};
      send_stream(1'b1);
      check_good_load("gaps");
      check("gaps_done",      32'(done), 32'd1);
      check("gaps_cpu_reset", 32'(cpu_reset), 32'd0);

      // Restart and reload without gaps.
      pulse_restart();
      check("rs2_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rs2_in_ready",  32'(in_ready), 32'd1);
      send_stream(1'b0);
      check_good_load("reload");
      check("reload_done",      32'(done), 32'd1);
      check("reload_cpu_reset", 32'(cpu_reset), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
